// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch front end and the opcode decoder:
// FSM states, instruction field positions and opcode encodings.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StValid = 2'd2
    } ifu_state_e;

    localparam int unsigned OPC_HI  = 14;
    localparam int unsigned OPC_LO  = 12;
    localparam int unsigned I_BIT   = 15;
    localparam int unsigned ADDR_HI = 11;

    // Memory-reference opcodes 000..110; 111 selects register/IO instructions.
    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpAdd = 3'b001;
    localparam logic [2:0] OpLda = 3'b010;
    localparam logic [2:0] OpSta = 3'b011;
    localparam logic [2:0] OpBun = 3'b100;
    localparam logic [2:0] OpBsa = 3'b101;
    localparam logic [2:0] OpIsz = 3'b110;
    localparam logic [2:0] OpReg = 3'b111;

    function automatic logic is_mem_ref(input logic [2:0] opcode);
        return opcode != OpReg;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory read bus and instruction-register handshake between the fetch unit
// (master) and its memory / decode / execute neighbours (slave).
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
);
    logic              MEM_RD;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_DATA;
    logic              MEM_ACK;
    logic [DATA_W-1:0] IR;
    logic [2:0]        IR_OPCODE;
    logic              IR_I;
    logic [ADDR_W-1:0] IR_ADDR;
    logic              IR_VALID;
    logic              IR_READY;

    modport master (
        output MEM_RD, MEM_ADDR, IR, IR_OPCODE, IR_I, IR_ADDR, IR_VALID,
        input  MEM_DATA, MEM_ACK, IR_READY
    );

    modport slave (
        input  MEM_RD, MEM_ADDR, IR, IR_OPCODE, IR_I, IR_ADDR, IR_VALID,
        output MEM_DATA, MEM_ACK, IR_READY
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: requests instruction words, holds them in IR until the
// execute stage consumes them, and owns the program counter.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 12,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    instruction_fetch_unit_if.master bus,
    input  logic                     PC_LOAD,
    input  logic [ADDR_W-1:0]        PC_LOAD_VAL,
    input  logic                     HALT,
    output logic [ADDR_W-1:0]        PC,
    output logic                     BUSY
);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              flush_q, flush_d;
    logic              mem_rd;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flush_d = flush_q;
        mem_rd  = 1'b0;

        case (state_q)
            StIdle: begin
                if (!HALT) state_d = StReq;
            end
            StReq: begin
                mem_rd = 1'b1;
                if (bus.MEM_ACK) begin
                    if (flush_q) begin
                        // Completion of a read issued before a branch: discard it.
                        flush_d = 1'b0;
                    end else begin
                        ir_d    = bus.MEM_DATA;
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = StValid;
                    end
                end else if (PC_LOAD) begin
                    flush_d = 1'b1;
                end
            end
            StValid: begin
                if (bus.IR_READY) state_d = HALT ? StIdle : StReq;
            end
            default: state_d = StIdle;
        endcase

        // A branch target always wins over the post-increment.
        if (PC_LOAD) pc_d = PC_LOAD_VAL;
    end

    assign bus.MEM_RD    = mem_rd;
    assign bus.MEM_ADDR  = pc_q;
    assign bus.IR        = ir_q;
    assign bus.IR_OPCODE = ir_q[OPC_HI:OPC_LO];
    assign bus.IR_I      = ir_q[I_BIT];
    assign bus.IR_ADDR   = ir_q[ADDR_HI:0];
    assign bus.IR_VALID  = (state_q == StValid);

    assign PC   = pc_q;
    assign BUSY = (state_q != StIdle);

endmodule
